// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder slice.
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam word_t       PAD_WORD        = 32'h8000_0000;
    localparam int unsigned WORDS_PER_BLOCK = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MSG,
        S_PAD,
        S_ZERO,
        S_LEN_HI,
        S_LEN_LO,
        S_DRAIN
    } padder_state_t;

    typedef struct packed {
        word_t      data;
        logic [3:0] idx;
        logic       last;
    } fifo_entry_t;

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Padded-word stream from the padder to the hash core (valid/ready).
interface sha256_msg_padder_if;
    import sha256_pkg::*;

    logic       w_valid;
    logic       w_ready;
    word_t      w_data;
    logic [3:0] w_idx;
    logic       w_last;

    modport master (output w_valid, w_data, w_idx, w_last, input w_ready);
    modport slave  (input w_valid, w_data, w_idx, w_last, output w_ready);

endinterface

// File: rtl/sha256_skid_fifo.sv
// Two-entry output FIFO carrying {data, idx, last}; head entry drives the stream.
module sha256_skid_fifo
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  fifo_entry_t din,
    output fifo_entry_t dout,
    output logic [1:0]  count
);

    fifo_entry_t slot [2];
    logic        wr_ptr;
    logic        rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= '0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= din;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    assign dout = slot[rd_ptr];

endmodule

// File: rtl/sha256_msg_padder.sv
// Reads a raw message from word memory, appends SHA-256 padding and length,
// and streams it as 16-word blocks to the hash core.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    message_addr,
    input  logic [LEN_W-1:0]     msg_words,
    output logic                 mem_clk,
    output logic                 mem_re,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_read_data,
    sha256_msg_padder_if.master  w,
    output logic [LEN_W-1:0]     num_blocks,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CW = LEN_W + 4;

    padder_state_t state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] rd_cnt;
    logic [CW-1:0]    push_cnt;
    logic [CW-1:0]    push_cnt_inc;
    logic [CW-1:0]    total;
    logic [LEN_W:0]   len_plus;
    logic [63:0]      bit_len;
    logic             pend;
    logic             pop;
    logic             push;
    logic             gen;
    logic             space_ok;
    logic [2:0]       occ;
    logic [1:0]       fifo_count;
    word_t            gen_word;
    fifo_entry_t      fifo_din;
    fifo_entry_t      fifo_dout;

    assign mem_clk      = clk;
    assign total        = CW'(num_blocks) * CW'(WORDS_PER_BLOCK);
    assign len_plus     = {1'b0, msg_words} + (LEN_W+1)'(18);
    assign bit_len      = {{(59-LEN_W){1'b0}}, len_q, 5'b0};
    assign push_cnt_inc = push_cnt + CW'(1);

    // Space counts the FIFO, the read whose data is on the bus now, and a pop this cycle.
    assign pop      = w.w_valid && w.w_ready;
    assign occ      = 3'(fifo_count) + 3'(pend) - 3'(pop);
    assign space_ok = occ < 3'd2;

    always_comb begin
        mem_re   = 1'b0;
        gen      = 1'b0;
        gen_word = '0;
        case (state)
            S_MSG:    mem_re = space_ok;
            S_PAD:    begin gen = space_ok && !pend; gen_word = PAD_WORD; end
            S_ZERO:   gen = space_ok && !pend;
            S_LEN_HI: begin gen = space_ok && !pend; gen_word = bit_len[63:32]; end
            S_LEN_LO: begin gen = space_ok && !pend; gen_word = bit_len[31:0]; end
            default:  ;
        endcase
    end

    // Returning read data always wins the push slot; generated words wait for it.
    assign push     = pend || gen;
    assign fifo_din = {pend ? word_t'(mem_read_data) : gen_word,
                       push_cnt[3:0],
                       push_cnt == total - CW'(1)};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            len_q      <= '0;
            rd_cnt     <= '0;
            push_cnt   <= '0;
            pend       <= 1'b0;
            mem_addr   <= '0;
            num_blocks <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            pend <= mem_re;
            if (push) begin
                push_cnt <= push_cnt_inc;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q      <= msg_words;
                        mem_addr   <= message_addr;
                        rd_cnt     <= '0;
                        push_cnt   <= '0;
                        num_blocks <= LEN_W'(len_plus >> 4);
                        busy       <= 1'b1;
                        state      <= (msg_words == '0) ? S_PAD : S_MSG;
                    end
                end
                S_MSG: begin
                    if (mem_re) begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                        rd_cnt   <= rd_cnt + LEN_W'(1);
                        if (rd_cnt + LEN_W'(1) == len_q) begin
                            state <= S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    if (gen) begin
                        state <= (push_cnt_inc == total - CW'(2)) ? S_LEN_HI : S_ZERO;
                    end
                end
                S_ZERO: begin
                    if (gen && push_cnt_inc == total - CW'(2)) begin
                        state <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (gen) begin
                        state <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (gen) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && fifo_dout.last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    sha256_skid_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign w.w_valid = fifo_count != 2'd0;
    assign w.w_data  = fifo_dout.data;
    assign w.w_idx   = fifo_dout.idx;
    assign w.w_last  = fifo_dout.last;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed and randomized checks of sha256_msg_padder against a padding model.
module tb_sha256_msg_padder;
    import sha256_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] message_addr;
    logic [15:0] msg_words;
    logic        mem_clk;
    logic        mem_re;
    logic [15:0] mem_addr;
    logic [31:0] mem_read_data;
    logic [15:0] num_blocks;
    logic        busy;
    logic        done;

    sha256_msg_padder_if w_if();

    sha256_msg_padder #(.ADDR_W(16), .DATA_W(32), .LEN_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .message_addr  (message_addr),
        .msg_words     (msg_words),
        .mem_clk       (mem_clk),
        .mem_re        (mem_re),
        .mem_addr      (mem_addr),
        .mem_read_data (mem_read_data),
        .w             (w_if.master),
        .num_blocks    (num_blocks),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [65536];
    logic [15:0] addr_log [$];

    always @(posedge clk) begin
        if (mem_re === 1'b1) begin
            mem_read_data <= mem[mem_addr];
            addr_log.push_back(mem_addr);
        end
    end

    typedef struct {
        logic [31:0] data;
        logic [3:0]  idx;
        logic        last;
    } obs_t;

    int unsigned vectors;
    int unsigned miscompares;
    logic [31:0] exp_q [$];
    logic [15:0] exp_addr [$];
    obs_t        got_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Padded length is the smallest multiple of 16 words holding msg + pad + 2 length words.
    task automatic build_model(input logic [15:0] addr, input int unsigned m);
        int unsigned total;
        logic [63:0] bits;
        logic [15:0] a;
        exp_q.delete();
        exp_addr.delete();
        total = ((m + 3 + 15) / 16) * 16;
        for (int unsigned k = 0; k < m; k++) begin
            a = addr + 16'(k);
            exp_addr.push_back(a);
            exp_q.push_back(mem[a]);
        end
        exp_q.push_back(32'h8000_0000);
        while (exp_q.size() < total - 2) exp_q.push_back(32'h0);
        bits = 64'(m) * 64'd32;
        exp_q.push_back(bits[63:32]);
        exp_q.push_back(bits[31:0]);
    endtask

    task automatic run_case(input string tag, input logic [15:0] addr, input int unsigned m,
                            input int unsigned ready_pct, input bit poke, input int reset_at);
        bit          finished;
        bit          stalled;
        obs_t        prev;
        obs_t        cur;
        int unsigned n;
        build_model(addr, m);
        got_q.delete();
        addr_log.delete();
        finished = 1'b0;
        stalled  = 1'b0;
        @(posedge clk); #1;
        message_addr   = addr;
        msg_words      = 16'(m);
        start          = 1'b1;
        w_if.w_ready   = ($urandom_range(99) < ready_pct);
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                check({tag, "/busy_after_start"}, 64'(busy), 64'd1);
                check({tag, "/num_blocks"}, 64'(num_blocks), 64'(exp_q.size() / 16));
            end
            cur = '{w_if.w_data, w_if.w_idx, w_if.w_last};
            if (stalled) begin
                check({tag, "/stall_valid"}, 64'(w_if.w_valid), 64'd1);
                check({tag, "/stall_data"}, 64'(cur.data), 64'(prev.data));
                check({tag, "/stall_idx"}, 64'(cur.idx), 64'(prev.idx));
                check({tag, "/stall_last"}, 64'(cur.last), 64'(prev.last));
            end
            stalled = w_if.w_valid && !w_if.w_ready;
            prev    = cur;
            if (w_if.w_valid && w_if.w_ready) got_q.push_back(cur);
            if (done === 1'b1) begin
                check({tag, "/busy_at_done"}, 64'(busy), 64'd0);
                finished = 1'b1;
            end else if (reset_at >= 0 && got_q.size() == reset_at) begin
                reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check({tag, "/rst_w_valid"}, 64'(w_if.w_valid), 64'd0);
                check({tag, "/rst_busy"}, 64'(busy), 64'd0);
                check({tag, "/rst_mem_re"}, 64'(mem_re), 64'd0);
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
            if (!finished) begin
                @(posedge clk); #1;
                w_if.w_ready = ($urandom_range(99) < ready_pct);
                if (poke && cyc == 3) begin
                    start     = 1'b1;
                    msg_words = 16'd3;
                end else if (poke && cyc == 4) begin
                    start     = 1'b0;
                    msg_words = 16'(m);
                end
            end
        end
        check({tag, "/done_seen"}, 64'(finished), 64'd1);
        @(negedge clk);
        check({tag, "/done_pulse_width"}, 64'(done), 64'd0);
        check({tag, "/word_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int unsigned i = 0; i < n; i++) begin
            check($sformatf("%s/data%0d", tag, i), 64'(got_q[i].data), 64'(exp_q[i]));
            check($sformatf("%s/idx%0d", tag, i), 64'(got_q[i].idx), 64'(i % 16));
            check($sformatf("%s/last%0d", tag, i), 64'(got_q[i].last), 64'(i == exp_q.size() - 1));
        end
        check({tag, "/addr_count"}, 64'(addr_log.size()), 64'(exp_addr.size()));
        n = (addr_log.size() < exp_addr.size()) ? addr_log.size() : exp_addr.size();
        for (int unsigned i = 0; i < n; i++) begin
            check($sformatf("%s/addr%0d", tag, i), 64'(addr_log[i]), 64'(exp_addr[i]));
        end
    endtask

    initial begin
        logic [15:0] ra;
        int unsigned rm;
        int unsigned rp;
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        start        = 1'b0;
        message_addr = '0;
        msg_words    = '0;
        w_if.w_ready = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom();
        for (int k = 0; k < 20; k++) mem[16'h0040 + k] = 32'(k + 1);
        mem[16'h0500] = 32'h0000_0001;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset/w_valid", 64'(w_if.w_valid), 64'd0);
        check("reset/mem_re", 64'(mem_re), 64'd0);
        check("reset/mem_addr", 64'(mem_addr), 64'd0);
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/done", 64'(done), 64'd0);
        check("reset/w_idx", 64'(w_if.w_idx), 64'd0);
        check("reset/w_last", 64'(w_if.w_last), 64'd0);
        check("reset/num_blocks", 64'(num_blocks), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("idle_ready/w_valid", 64'(w_if.w_valid), 64'd0);

        run_case("t1_len0", 16'h0100, 0, 100, 1'b0, -1);
        run_case("t2_len20", 16'h0040, 20, 100, 1'b0, -1);
        run_case("t3_len13", 16'h0200, 13, 100, 1'b0, -1);
        run_case("t3_len14", 16'h0300, 14, 100, 1'b0, -1);
        run_case("t4_stall", 16'h0040, 20, 50, 1'b0, -1);
        run_case("t5_reset", 16'h0040, 20, 100, 1'b0, 7);
        run_case("t5_fresh", 16'h0500, 1, 100, 1'b0, -1);
        run_case("t6_poke", 16'h0040, 20, 100, 1'b1, -1);
        for (int r = 0; r < 6; r++) begin
            ra = 16'($urandom_range(0, 16'hF000));
            rm = $urandom_range(0, 40);
            rp = $urandom_range(30, 100);
            run_case($sformatf("rand%0d", r), ra, rm, rp, 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
